// File: rtl/csc_sequencer.sv
// Two-cycle FETCH/EXEC sequencer for the CSC microcoded machine: it addresses the
// top ROM, latches the instruction word, and updates PC, flags and the A/B registers.
module csc_sequencer #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic [7:0]        ctrl,
  input  logic [7:0]        jaddr,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [3:0]        alu_nzvc,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [7:0]        pc,
  output logic [3:0]        nzvc,
  output logic              rom_en_n,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] areg,
  output logic [DATA_W-1:0] breg,
  output logic              ram_we,
  output logic              halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Latched control bits [7:3]; the ALUop field lives on in alu_op.
  logic [7:3] ir_ctrl_p1;
  logic [7:0] ir_jaddr_p1;

  logic pc_incr, a_load, b_load, a_sel, ram_write, halt_hit;

  assign pc_incr   = ir_ctrl_p1[3];
  assign a_load    = ir_ctrl_p1[4];
  assign b_load    = ir_ctrl_p1[5];
  assign a_sel     = ir_ctrl_p1[6];
  assign ram_write = ir_ctrl_p1[7];

  // A jump onto itself is the program's way of saying "stop here".
  assign halt_hit  = !pc_incr && (ir_jaddr_p1 == pc);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run || step) state_nxt = FETCH;
      FETCH:   state_nxt = EXEC;
      EXEC: begin
        if (halt_hit)  state_nxt = HALT;
        else if (run)  state_nxt = FETCH;
        else           state_nxt = IDLE;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  assign rom_en_n = (state != FETCH);
  assign ram_we   = (state == EXEC) && ram_write;
  assign halted   = (state == HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= 8'h00;
      nzvc        <= 4'h0;
      areg        <= '0;
      breg        <= '0;
      alu_op      <= 3'b000;
      ir_ctrl_p1  <= '0;
      ir_jaddr_p1 <= 8'h00;
    end else begin
      state <= state_nxt;
      // FETCH -> EXEC boundary: capture the ROM outputs while they are valid
      if (state == FETCH) begin
        ir_ctrl_p1  <= ctrl[7:3];
        ir_jaddr_p1 <= jaddr;
        alu_op      <= ctrl[2:0];
      end
      // EXEC -> next boundary: commit the instruction's architectural effects
      if (state == EXEC) begin
        pc   <= pc_incr ? pc + 8'd1 : ir_jaddr_p1;
        nzvc <= alu_nzvc;
        if (a_load) areg <= a_sel ? ram_rdata : alu_res;
        if (b_load) breg <= alu_res;
      end
    end
  end

endmodule

// File: tb/tb_csc_sequencer.sv
// Directed bench for csc_sequencer: a reference model pushes expected post-EXEC state
// into a queue as each instruction is issued, and the entry is popped once EXEC retires.
module tb_csc_sequencer;

  logic       clk = 1'b0;
  logic       reset, run, step;
  logic [7:0] ctrl, jaddr;
  logic [3:0] alu_res, alu_nzvc, ram_rdata;
  logic [7:0] pc;
  logic [3:0] nzvc, areg, breg;
  logic       rom_en_n, ram_we, halted;
  logic [2:0] alu_op;

  csc_sequencer #(.DATA_W(4)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .ctrl(ctrl), .jaddr(jaddr), .alu_res(alu_res), .alu_nzvc(alu_nzvc),
    .ram_rdata(ram_rdata), .pc(pc), .nzvc(nzvc), .rom_en_n(rom_en_n),
    .alu_op(alu_op), .areg(areg), .breg(breg), .ram_we(ram_we), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pc;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] nzvc;
    logic       halted;
  } exp_t;

  exp_t sb[$];

  int passed = 0;
  int total  = 0;

  logic [7:0] m_pc;
  logic [3:0] m_a, m_b, m_nzvc;
  logic       m_halt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_a = 4'h0; m_b = 4'h0; m_nzvc = 4'h0; m_halt = 1'b0;
    sb.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; step = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Issue one instruction; in step mode pulse step, otherwise rely on run being high.
  task automatic do_instr(input logic [7:0] c, input logic [7:0] j, input logic [3:0] res,
                          input logic [3:0] flg, input logic [3:0] rd, input bit use_step);
    exp_t e;
    bit   found;
    ctrl = c; jaddr = j; alu_res = res; alu_nzvc = flg; ram_rdata = rd;
    if (c[4]) m_a = c[6] ? rd : res;
    if (c[5]) m_b = res;
    m_nzvc = flg;
    m_halt = !c[3] && (j == m_pc);
    m_pc   = c[3] ? m_pc + 8'd1 : j;
    e.pc = m_pc; e.a = m_a; e.b = m_b; e.nzvc = m_nzvc; e.halted = m_halt;
    sb.push_back(e);
    if (use_step) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
    end
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rom_en_n === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      check("fetch_timeout", 32'd0, 32'd1);
      return;
    end
    check("fetch_we", ram_we, 1'b0);
    @(negedge clk);
    check("exec_rom_en_n", rom_en_n, 1'b1);
    check("exec_we", ram_we, c[7]);
    check("exec_alu_op", alu_op, c[2:0]);
    @(negedge clk);
    e = sb.pop_front();
    check("pc", pc, e.pc);
    check("areg", areg, e.a);
    check("breg", breg, e.b);
    check("nzvc", nzvc, e.nzvc);
    check("halted", halted, e.halted);
    check("post_we", ram_we, 1'b0);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0;
    ctrl = 8'h00; jaddr = 8'h00; alu_res = 4'h0; alu_nzvc = 4'h0; ram_rdata = 4'h0;
    do_reset();

    // Reset state
    check("rst_pc", pc, 8'h00);
    check("rst_nzvc", nzvc, 4'h0);
    check("rst_areg", areg, 4'h0);
    check("rst_breg", breg, 4'h0);
    check("rst_alu_op", alu_op, 3'b000);
    check("rst_rom_en_n", rom_en_n, 1'b1);
    check("rst_we", ram_we, 1'b0);
    check("rst_halted", halted, 1'b0);

    // Free-run increment, then drop run mid-instruction
    run = 1'b1;
    for (int k = 0; k < 4; k++) do_instr(8'h08, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0);
    run = 1'b0;
    do_instr(8'h08, 8'h00, 4'h0, 4'h2, 4'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("run_drop_idle", rom_en_n, 1'b1);
      check("run_drop_pc", pc, 8'h05);
    end

    // Single step: load A and B from the ALU
    do_reset();
    do_instr(8'h38, 8'h00, 4'h5, 4'h0, 4'h0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("step_idle_pc", pc, 8'h01);
      check("step_idle_rom", rom_en_n, 1'b1);
    end

    // A from RAM with B untouched, a RAM write, then a B load with a nonzero ALUop
    do_instr(8'h58, 8'h00, 4'h3, 4'h9, 4'hA, 1'b1);
    do_instr(8'h88, 8'h00, 4'h1, 4'h4, 4'h0, 1'b1);
    do_instr(8'h2F, 8'h00, 4'hC, 4'h8, 4'h0, 1'b1);

    // Step pulse outside IDLE must not start a second instruction
    ctrl = 8'h08; step = 1'b1;
    @(negedge clk);
    check("step2_fetch", rom_en_n, 1'b0);
    @(negedge clk);
    check("step2_exec", rom_en_n, 1'b1);
    step = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("step2_idle", rom_en_n, 1'b1);
    check("step2_pc", pc, 8'h05);

    // Reset lands in the middle of EXEC
    ctrl = 8'h18; alu_res = 4'h7; alu_nzvc = 4'hF; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("rexec_fetch", rom_en_n, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rexec_areg", areg, 4'h0);
    check("rexec_nzvc", nzvc, 4'h0);
    check("rexec_pc", pc, 8'h00);
    check("rexec_rom", rom_en_n, 1'b1);
    check("rexec_we", ram_we, 1'b0);
    check("rexec_alu_op", alu_op, 3'b000);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rexec_idle", rom_en_n, 1'b1);

    // PC wrap from 0xFF
    do_instr(8'h00, 8'hFF, 4'h0, 4'h0, 4'h0, 1'b1);
    do_instr(8'h08, 8'h00, 4'h0, 4'h1, 4'h0, 1'b1);

    // Jump to 0x10, then a self-jump halts; run and step are then ignored
    run = 1'b1;
    do_instr(8'h00, 8'h10, 4'h0, 4'h0, 4'h0, 1'b0);
    do_instr(8'h00, 8'h10, 4'h6, 4'h3, 4'h0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      run  = k[0];
      step = ~k[0];
      @(negedge clk);
      check("halt_pc", pc, 8'h10);
      check("halt_flag", halted, 1'b1);
      check("halt_rom", rom_en_n, 1'b1);
    end
    run = 1'b0; step = 1'b0;
    do_reset();
    check("halt_rst_pc", pc, 8'h00);
    check("halt_rst_flag", halted, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
